// File: rtl/hadamard_pkg.sv
// Shared constants and elaboration helpers for the pipelined fast Walsh-Hadamard transform.
package hadamard_pkg;

    localparam int unsigned HAD_MAX_N = 64;

    localparam bit HAD_FWD = 1'b0;
    localparam bit HAD_INV = 1'b1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Result width of butterfly stage s fed by dw-bit samples (one bit of growth per stage).
    function automatic int unsigned stage_w(input int unsigned dw, input int unsigned s);
        return dw + s + 1;
    endfunction

endpackage

// File: rtl/hadamard_bfly_stage.sv
// One FWHT butterfly stage: N/2 add/sub pairs at distance 2^S, then the stage register.
// The last stage also applies the 1/N arithmetic shift for inverse-mode vectors.
module hadamard_bfly_stage
    import hadamard_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IW   = 9,
    parameter int unsigned S    = 0,
    parameter bit          LAST = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic                in_inv,
    input  logic [N*IW-1:0]     x_in,
    output logic                out_valid,
    output logic                out_inv,
    output logic [N*(IW+1)-1:0] y_out
);

    localparam int unsigned OWS  = stage_w(IW - S, S);
    localparam int unsigned SPAN = int'(1) << S;
    localparam int unsigned SH   = S + 1;

    logic [N*OWS-1:0] bfly_c;
    logic [N*OWS-1:0] next_c;

    // Pair p covers lower index LO (bit S clear) and upper index LO+2^S.
    for (genvar p = 0; p < N / 2; p++) begin : g_bfly
        localparam int unsigned PU = int'(p);
        localparam int unsigned LO = ((PU / SPAN) * 2 * SPAN) + (PU % SPAN);
        localparam int unsigned HI = LO + SPAN;

        logic signed [OWS-1:0] a;
        logic signed [OWS-1:0] b;

        assign a = {x_in[LO*IW + IW - 1], x_in[LO*IW +: IW]};
        assign b = {x_in[HI*IW + IW - 1], x_in[HI*IW +: IW]};

        assign bfly_c[LO*OWS +: OWS] = a + b;
        assign bfly_c[HI*OWS +: OWS] = a - b;
    end

    if (LAST) begin : g_inv
        // After the final stage every sum carries a factor of N = 2^(S+1); floor-divide it out.
        for (genvar k = 0; k < N; k++) begin : g_shift
            logic signed [OWS-1:0] sum;
            assign sum = bfly_c[k*OWS +: OWS];
            assign next_c[k*OWS +: OWS] = (in_inv == HAD_INV) ? (sum >>> SH) : sum;
        end
    end else begin : g_pass
        assign next_c = bfly_c;
    end

    // Bubbles load zero data so an idle output bus reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inv   <= HAD_FWD;
            y_out     <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_inv   <= in_valid ? in_inv : HAD_FWD;
            y_out     <= in_valid ? next_c : '0;
        end
    end

endmodule

// File: rtl/hadamard_fwht_pipe.sv
// N-point Sylvester-order fast Walsh-Hadamard transform, one butterfly stage per register,
// one vector per cycle, global stall on output back-pressure.
module hadamard_fwht_pipe
    import hadamard_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned DW    = 9,
    localparam int unsigned LOG2N = clog2(N),
    localparam int unsigned OW    = DW + LOG2N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [N*DW-1:0]   x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*OW-1:0]   y_out
);

    if ((N < 2) || (N > HAD_MAX_N) || !is_pow2(N)) begin : g_bad_n
        $error("hadamard_fwht_pipe: N=%0d must be a power of two in 2..%0d", N, HAD_MAX_N);
    end

    logic en;

    // All stages advance together whenever the output slot is free or being drained.
    assign en       = !rst && (out_ready || !out_valid);
    assign in_ready = en;

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int unsigned IW = DW + s;

        logic                v;
        logic                inv;
        logic [N*(IW+1)-1:0] d;

        if (s == 0) begin : g_first
            hadamard_bfly_stage #(
                .N    (N),
                .IW   (IW),
                .S    (0),
                .LAST (LOG2N == 1)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .in_valid  (in_valid),
                .in_inv    (in_inv),
                .x_in      (x_in),
                .out_valid (v),
                .out_inv   (inv),
                .y_out     (d)
            );
        end else begin : g_next
            hadamard_bfly_stage #(
                .N    (N),
                .IW   (IW),
                .S    (s),
                .LAST (s == LOG2N - 1)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .in_valid  (g_stage[s-1].v),
                .in_inv    (g_stage[s-1].inv),
                .x_in      (g_stage[s-1].d),
                .out_valid (v),
                .out_inv   (inv),
                .y_out     (d)
            );
        end
    end

    assign out_valid = g_stage[LOG2N-1].v;
    assign y_out     = g_stage[LOG2N-1].d;

    // The mode tag has already been consumed by the final shift.
    logic unused_last_inv;
    assign unused_last_inv = g_stage[LOG2N-1].inv;

endmodule

// File: tb/tb_hadamard_fwht_pipe.sv
// Directed bench for hadamard_fwht_pipe at N=4 and N=8 with an expected-result queue per instance.
module tb_hadamard_fwht_pipe;

    localparam int unsigned DW  = 9;
    localparam int unsigned N4  = 4;
    localparam int unsigned OW4 = 11;
    localparam int unsigned X4  = N4 * DW;
    localparam int unsigned Y4  = N4 * OW4;
    localparam int unsigned N8  = 8;
    localparam int unsigned OW8 = 12;
    localparam int unsigned X8  = N8 * DW;
    localparam int unsigned Y8  = N8 * OW8;

    typedef int vec_t [8];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
    logic [X4-1:0] x_in4;
    logic [Y4-1:0] y_out4;
    logic          in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
    logic [X8-1:0] x_in8;
    logic [Y8-1:0] y_out8;

    int errors = 0;
    int checks = 0;

    logic [Y4-1:0] sb4 [$];
    logic [Y8-1:0] sb8 [$];

    always #5 clk = ~clk;

    hadamard_fwht_pipe #(.N(N4), .DW(DW)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_inv    (in_inv4),
        .x_in      (x_in4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .y_out     (y_out4)
    );

    hadamard_fwht_pipe #(.N(N8), .DW(DW)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_inv    (in_inv8),
        .x_in      (x_in8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .y_out     (y_out8)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(input int n, input int w, input vec_t v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < w; b++)
                r[k*w + b] = v[k][b];
        return r;
    endfunction

    // Direct definition: y_k = sum_j (-1)^popcount(j&k) x_j, floor-divided by n when inverse.
    function automatic logic [127:0] model(input int n, input int w, input vec_t x, input bit inv);
        vec_t y;
        int   lg;
        lg = $clog2(n);
        for (int k = 0; k < 8; k++) y[k] = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < n; j++) begin
                if ($countones(j & k) % 2 == 1) y[k] -= x[j];
                else                            y[k] += x[j];
            end
            if (inv) y[k] = y[k] >>> lg;
        end
        return pack(n, w, y);
    endfunction

    task automatic send4(input vec_t x, input bit inv, input logic [127:0] exp);
        bit done;
        done      = 1'b0;
        x_in4     = X4'(pack(N4, DW, x));
        in_inv4   = inv;
        in_valid4 = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready4) begin
                sb4.push_back(Y4'(exp));
                done = 1'b1;
            end
        end
        chk1("accept4", done, 1'b1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
    endtask

    task automatic send8(input vec_t x, input bit inv, input logic [127:0] exp);
        bit done;
        done      = 1'b0;
        x_in8     = X8'(pack(N8, DW, x));
        in_inv8   = inv;
        in_valid8 = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                sb8.push_back(Y8'(exp));
                done = 1'b1;
            end
        end
        chk1("accept8", done, 1'b1);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
    endtask

    task automatic drain4();
        for (int i = 0; i < 40; i++) begin
            if (sb4.size() == 0) break;
            @(negedge clk);
        end
        chkv("drain4", 128'(sb4.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic drain8();
        for (int i = 0; i < 40; i++) begin
            if (sb8.size() == 0) break;
            @(negedge clk);
        end
        chkv("drain8", 128'(sb8.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Output side: every completed handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            chk1("extra4", sb4.size() != 0, 1'b1);
            if (sb4.size() != 0) chkv("y4", 128'(y_out4), 128'(sb4.pop_front()));
        end
        if (!rst && out_valid8 && out_ready8) begin
            chk1("extra8", sb8.size() != 0, 1'b1);
            if (sb8.size() != 0) chkv("y8", 128'(y_out8), 128'(sb8.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t xa;
        vec_t ya;
        vec_t bp [4];

        rst        = 1'b1;
        in_valid4  = 1'b0;
        in_inv4    = 1'b0;
        x_in4      = '0;
        out_ready4 = 1'b1;
        in_valid8  = 1'b0;
        in_inv8    = 1'b0;
        x_in8      = '0;
        out_ready8 = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready4", in_ready4, 1'b0);
        chk1("rst_out_valid4", out_valid4, 1'b0);
        chkv("rst_y4", 128'(y_out4), 128'(0));
        chk1("rst_in_ready8", in_ready8, 1'b0);
        chk1("rst_out_valid8", out_valid8, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Forward (1,2,3,4): latency 2, single-cycle valid
        xa = '{1, 2, 3, 4, 0, 0, 0, 0};
        ya = '{10, -2, -4, 0, 0, 0, 0, 0};
        send4(xa, 1'b0, pack(N4, OW4, ya));
        @(negedge clk) chk1("lat4_c1", out_valid4, 1'b0);
        @(negedge clk) chk1("lat4_c2", out_valid4, 1'b1);
        @(negedge clk) chk1("lat4_c3", out_valid4, 1'b0);
        @(posedge clk);
        #1;

        // Inverse of the same vector, then the width extremes back to back
        ya = '{2, -1, -1, 0, 0, 0, 0, 0};
        send4(xa, 1'b1, pack(N4, OW4, ya));
        xa = '{-256, -256, -256, -256, 0, 0, 0, 0};
        ya = '{-1024, 0, 0, 0, 0, 0, 0, 0};
        send4(xa, 1'b0, pack(N4, OW4, ya));
        xa = '{-256, 255, 255, 255, 0, 0, 0, 0};
        ya = '{509, -511, -511, -511, 0, 0, 0, 0};
        send4(xa, 1'b0, pack(N4, OW4, ya));
        drain4();

        // Back-pressure: four vectors streamed while the sink stalls for four cycles
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++)
                bp[i][j] = (j < 4) ? (i * 61 - j * 37 + 5) : 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send4(bp[i], 1'b0, model(N4, OW4, bp[i], 1'b0));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 out_ready4 = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk1("stall_valid4", out_valid4, 1'b1);
                    chk1("stall_in_ready4", in_ready4, 1'b0);
                    chkv("stall_y4", 128'(y_out4), 128'(sb4[0]));
                end
                @(posedge clk);
                #1 out_ready4 = 1'b1;
            end
        join
        drain4();

        // Mid-operation reset discards the in-flight vector
        xa = '{5, -7, 100, -3, 0, 0, 0, 0};
        send4(xa, 1'b0, model(N4, OW4, xa, 1'b0));
        rst = 1'b1;
        sb4.delete();
        xa = '{9, 9, 9, 9, 0, 0, 0, 0};
        x_in4     = X4'(pack(N4, DW, xa));
        in_valid4 = 1'b1;
        @(negedge clk);
        chk1("mid_rst_in_ready4", in_ready4, 1'b0);
        chk1("mid_rst_valid4", out_valid4, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1("post_rst_valid4", out_valid4, 1'b0);
            chkv("post_rst_y4", 128'(y_out4), 128'(0));
        end
        @(posedge clk);
        #1;
        xa = '{-100, 37, 0, 255, 0, 0, 0, 0};
        send4(xa, 1'b1, model(N4, OW4, xa, 1'b1));
        @(negedge clk) chk1("rlat4_c1", out_valid4, 1'b0);
        @(negedge clk) chk1("rlat4_c2", out_valid4, 1'b1);
        drain4();

        // N=8 impulse at x1: latency 3
        xa = '{0, 1, 0, 0, 0, 0, 0, 0};
        ya = '{1, -1, 1, -1, 1, -1, 1, -1};
        send8(xa, 1'b0, pack(N8, OW8, ya));
        @(negedge clk) chk1("lat8_c1", out_valid8, 1'b0);
        @(negedge clk) chk1("lat8_c2", out_valid8, 1'b0);
        @(negedge clk) chk1("lat8_c3", out_valid8, 1'b1);
        @(posedge clk);
        #1;

        // N=8 alternating forward/inverse at full rate
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) xa[j] = int'($urandom_range(511, 0)) - 256;
            send8(xa, i[0], model(N8, OW8, xa, i[0]));
        end
        drain8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
